box_draw_ctrl: RTL and testbench



---
 rtl/draw_pkg.sv | 35 +++
 rtl/box_draw_ctrl_raster_counter.sv | 50 +++++
 rtl/box_draw_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_box_draw_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared screen geometry, state encoding, colours and command payload for the
// box drawing path.
package draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned SIZE_W   = 5;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  // Rectangle command as latched at accept
  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [SIZE_W-1:0]   w;
    logic [SIZE_W-1:0]   h;
    logic [COLOUR_W-1:0] colour;
  } cmd_t;

  // True when a widened pixel coordinate lands inside the visible area
  function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy);
    return (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/box_draw_ctrl_raster_counter.sv
// Row-major cx/cy walker bounded by w/h. Exposes the coordinate that follows
// the current one plus a flag on the final pixel, so callers can register
// pixel outputs one cycle ahead.
module raster_counter
  import draw_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [SIZE_W-1:0] w_i,
  input  logic [SIZE_W-1:0] h_i,
  output logic [SIZE_W-1:0] nxt_cx_c,
  output logic [SIZE_W-1:0] nxt_cy_c,
  output logic              last_c
);

  logic [SIZE_W-1:0] cx_q, cx_d;
  logic [SIZE_W-1:0] cy_q, cy_d;
  logic              row_end;

  // Next coordinate and end-of-box detection
  always_comb begin
    row_end  = (cx_q == SIZE_W'(w_i - SIZE_W'(1)));
    last_c   = row_end && (cy_q == SIZE_W'(h_i - SIZE_W'(1)));
    nxt_cx_c = row_end ? '0 : SIZE_W'(cx_q + SIZE_W'(1));
    nxt_cy_c = row_end ? SIZE_W'(cy_q + SIZE_W'(1)) : cy_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    if (load_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step_i) begin
      cx_d = nxt_cx_c;
      cy_d = nxt_cy_c;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/box_draw_ctrl.sv
// Rasterises one draw/erase rectangle command into one VGA pixel write per
// clock in row-major order. Off-screen pixels consume a cycle with plot low.
// Optional BOX_OUTLINE_EN adds req_outline: only border pixels are plotted.
module box_draw_ctrl
  import draw_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [X_W-1:0]      req_x,
  input  logic [Y_W-1:0]      req_y,
  input  logic [SIZE_W-1:0]   req_w,
  input  logic [SIZE_W-1:0]   req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  input  logic                req_erase,
  input  logic [COLOUR_W-1:0] bg_colour,
`ifdef BOX_OUTLINE_EN
  input  logic                req_outline,
`endif
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                plot_q, plot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
`ifdef BOX_OUTLINE_EN
  logic                outline_q, outline_d;
  logic                px_outline;
  logic                px_border;
`endif

  logic                load_c, step_c;
  logic [SIZE_W-1:0]   nxt_cx_c, nxt_cy_c;
  logic                last_c;

  // Pixel being emitted this cycle: base, offset, size and colour
  logic                px_emit;
  logic [X_W-1:0]      px_base_x;
  logic [Y_W-1:0]      px_base_y;
  logic [SIZE_W-1:0]   px_off_x, px_off_y;
  logic [SIZE_W-1:0]   px_w, px_h;
  logic [COLOUR_W-1:0] px_colour;
  logic [X_W:0]        px_sx;
  logic [Y_W:0]        px_sy;

  raster_counter u_raster (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (load_c),
    .step_i   (step_c),
    .w_i      (cmd_q.w),
    .h_i      (cmd_q.h),
    .nxt_cx_c (nxt_cx_c),
    .nxt_cy_c (nxt_cy_c),
    .last_c   (last_c)
  );

  // Next state, command latch and next registered pixel outputs
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    plot_d       = 1'b0;
    load_c       = 1'b0;
    step_c       = 1'b0;
    px_emit      = 1'b0;
    px_base_x    = cmd_q.x;
    px_base_y    = cmd_q.y;
    px_off_x     = nxt_cx_c;
    px_off_y     = nxt_cy_c;
    px_w         = cmd_q.w;
    px_h         = cmd_q.h;
    px_colour    = cmd_q.colour;
`ifdef BOX_OUTLINE_EN
    outline_d    = outline_q;
    px_outline   = outline_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d.x      = req_x;
          cmd_d.y      = req_y;
          cmd_d.w      = req_w;
          cmd_d.h      = req_h;
          cmd_d.colour = req_erase ? bg_colour : req_colour;
          load_c       = 1'b1;
`ifdef BOX_OUTLINE_EN
          outline_d    = req_outline;
          px_outline   = req_outline;
`endif
          if ((req_w == '0) || (req_h == '0)) begin
            state_d = DONE;
          end else begin
            // First pixel comes straight from the request so it appears at T+1
            state_d   = PLOT;
            px_emit   = 1'b1;
            px_base_x = req_x;
            px_base_y = req_y;
            px_off_x  = '0;
            px_off_y  = '0;
            px_w      = req_w;
            px_h      = req_h;
            px_colour = cmd_d.colour;
          end
        end
      end
      PLOT: begin
        if (last_c) begin
          state_d = DONE;
        end else begin
          step_c  = 1'b1;
          px_emit = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    px_sx = {1'b0, px_base_x} + (X_W+1)'(px_off_x);
    px_sy = {1'b0, px_base_y} + (Y_W+1)'(px_off_y);
`ifdef BOX_OUTLINE_EN
    px_border = (px_off_x == '0) || (px_off_x == SIZE_W'(px_w - SIZE_W'(1))) ||
                (px_off_y == '0) || (px_off_y == SIZE_W'(px_h - SIZE_W'(1)));
`endif

    if (px_emit) begin
      vga_x_d      = px_sx[X_W-1:0];
      vga_y_d      = px_sy[Y_W-1:0];
      vga_colour_d = px_colour;
`ifdef BOX_OUTLINE_EN
      plot_d       = on_screen(px_sx, px_sy) && (!px_outline || px_border);
`else
      plot_d       = on_screen(px_sx, px_sy) && (px_w != '0) && (px_h != '0);
`endif
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
`ifdef BOX_OUTLINE_EN
      outline_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
`ifdef BOX_OUTLINE_EN
      outline_q    <= outline_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_box_draw_ctrl.sv
// Directed bench for box_draw_ctrl: filled, erase, clipped, empty and
// reset-abort boxes (plus outline boxes when BOX_OUTLINE_EN is defined).
module tb_box_draw_ctrl;
  import draw_pkg::*;

  logic                clock;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic [SIZE_W-1:0]   req_w;
  logic [SIZE_W-1:0]   req_h;
  logic [COLOUR_W-1:0] req_colour;
  logic                req_erase;
  logic [COLOUR_W-1:0] bg_colour;
`ifdef BOX_OUTLINE_EN
  logic                req_outline;
`endif
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                busy;
  logic                done;

  int tests_run;
  int tests_failed;

  box_draw_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .req_erase  (req_erase),
    .bg_colour  (bg_colour),
`ifdef BOX_OUTLINE_EN
    .req_outline(req_outline),
`endif
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one command and check every cycle up to ready returning.
  // nplots returns the number of cycles that actually asserted vga_plot.
  task automatic run_box(input string tag, input int x, input int y, input int w,
                         input int h, input int col, input int erase, input int bg,
                         input int exp_col, input int outline, output int nplots);
    int n, cx, cy, ex, ey, vis;
    nplots = 0;
    check({tag, " ready_before"}, 32'(req_ready), 32'd1);
    req_x      = X_W'(x);
    req_y      = Y_W'(y);
    req_w      = SIZE_W'(w);
    req_h      = SIZE_W'(h);
    req_colour = COLOUR_W'(col);
    req_erase  = erase[0];
    bg_colour  = COLOUR_W'(bg);
`ifdef BOX_OUTLINE_EN
    req_outline = outline[0];
`endif
    req_valid  = 1'b1;
    tick();
    // Scramble inputs after accept; they must have no effect
    req_valid  = 1'b0;
    req_x      = X_W'($urandom);
    req_y      = Y_W'($urandom);
    req_w      = SIZE_W'($urandom);
    req_h      = SIZE_W'($urandom);
    req_colour = ~COLOUR_W'(col);
    bg_colour  = ~COLOUR_W'(bg);
    n = w * h;
    for (int k = 0; k < n; k++) begin
      cx  = k % w;
      cy  = k / w;
      ex  = x + cx;
      ey  = y + cy;
      vis = (ex < 160 && ey < 120) ? 1 : 0;
      if (outline != 0 && !(cx == 0 || cx == w - 1 || cy == 0 || cy == h - 1)) vis = 0;
      check($sformatf("%s px%0d x", tag, k), 32'(vga_x), 32'(ex & 8'hff));
      check($sformatf("%s px%0d y", tag, k), 32'(vga_y), 32'(ey & 7'h7f));
      check($sformatf("%s px%0d colour", tag, k), 32'(vga_colour), 32'(exp_col));
      check($sformatf("%s px%0d plot", tag, k), 32'(vga_plot), 32'(vis));
      check($sformatf("%s px%0d busy", tag, k), 32'(busy), 32'd1);
      check($sformatf("%s px%0d done", tag, k), 32'(done), 32'd0);
      nplots += int'(vga_plot);
      tick();
    end
    check({tag, " done_pulse"}, 32'(done), 32'd1);
    check({tag, " done_plot"}, 32'(vga_plot), 32'd0);
    check({tag, " done_busy"}, 32'(busy), 32'd1);
    check({tag, " done_ready"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, " idle_done"}, 32'(done), 32'd0);
    check({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_plot"}, 32'(vga_plot), 32'd0);
  endtask

  initial begin
    int np;
    tests_run    = 0;
    tests_failed = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_w      = '0;
    req_h      = '0;
    req_colour = '0;
    req_erase  = 1'b0;
    bg_colour  = '0;
`ifdef BOX_OUTLINE_EN
    req_outline = 1'b0;
`endif
    tick();
    tick();
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst plot", 32'(vga_plot), 32'd0);
    check("rst x", 32'(vga_x), 32'd0);
    check("rst y", 32'(vga_y), 32'd0);
    check("rst colour", 32'(vga_colour), 32'd0);
    reset = 1'b0;
    tick();

    // 3x2 filled box at (10,20)
    run_box("fill", 10, 20, 3, 2, 3'b100, 0, 3'b000, 3'b100, 0, np);
    check("fill plots", 32'(np), 32'd6);
    // Idle holds the last pixel position and colour
    check("hold x", 32'(vga_x), 32'd12);
    check("hold y", 32'(vga_y), 32'd21);
    check("hold colour", 32'(vga_colour), 32'd4);

    // Erase uses background colour
    run_box("erase", 0, 0, 2, 2, WHITE, 1, BLACK, BLACK, 0, np);
    check("erase plots", 32'(np), 32'd4);

    // Clipped at the bottom-right corner
    run_box("clip", 158, 119, 4, 2, 3'b010, 0, 3'b000, 3'b010, 0, np);
    check("clip plots", 32'(np), 32'd2);

    // Empty box completes immediately
    run_box("empty", 30, 30, 0, 5, 3'b011, 0, 3'b000, 3'b011, 0, np);
    check("empty plots", 32'(np), 32'd0);

    // Far-off-screen x with wide sum must not wrap onto visible pixels
    run_box("wrap", 250, 5, 8, 1, 3'b001, 0, 3'b000, 3'b001, 0, np);
    check("wrap plots", 32'(np), 32'd0);

    // Reset in the third PLOT cycle of a 4x4 box
    req_x      = 8'd5;
    req_y      = 7'd5;
    req_w      = 5'd4;
    req_h      = 5'd4;
    req_colour = 3'b010;
    req_erase  = 1'b0;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    check("abort px0 plot", 32'(vga_plot), 32'd1);
    tick();
    tick();
    check("abort px2 x", 32'(vga_x), 32'd7);
    check("abort px2 plot", 32'(vga_plot), 32'd1);
    reset = 1'b1;
    tick();
    check("abort plot", 32'(vga_plot), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort x", 32'(vga_x), 32'd0);
    reset = 1'b0;
    tick();
    check("abort stays idle", 32'(vga_plot), 32'd0);
    run_box("after_abort", 1, 2, 1, 1, WHITE, 0, BLACK, WHITE, 0, np);
    check("after_abort plots", 32'(np), 32'd1);

`ifdef BOX_OUTLINE_EN
    run_box("outline", 40, 40, 3, 3, 3'b110, 0, 3'b000, 3'b110, 1, np);
    check("outline plots", 32'(np), 32'd8);
    run_box("outline_off", 40, 40, 3, 3, 3'b110, 0, 3'b000, 3'b110, 0, np);
    check("outline_off plots", 32'(np), 32'd9);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
